// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: state encoding, default
// resolution / sample length, and the averaging pass-count width.
package sar_pkg;

    localparam int SAR_N_BITS     = 8;
    localparam int SAR_SAMPLE_CYC = 4;

    // Averaging mode runs a fixed number of passes per accepted start.
    localparam int SAR_PASSES     = 4;
    localparam int SAR_PASS_W     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_e;

endpackage

// File: rtl/sar_avg_accum.sv
// Pass accumulator for the 4x averaging build: sums per-pass codes in an
// N_BITS+2 wide register and tracks which pass is in flight. avg_o already
// includes the code being added this cycle, so the top can latch the average
// on the final pass without an extra cycle.
module sar_avg_accum
    import sar_pkg::*;
#(
    parameter int N_BITS = SAR_N_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [N_BITS-1:0] code_i,
    output logic              last_o,
    output logic [N_BITS-1:0] avg_o
);

    logic [N_BITS+1:0]     sum_q;
    logic [N_BITS+1:0]     sum_nxt;
    logic [SAR_PASS_W-1:0] pass_q;

    assign sum_nxt = sum_q + {2'b00, code_i};
    assign avg_o   = sum_nxt[N_BITS+1:2];
    assign last_o  = (pass_q == SAR_PASS_W'(SAR_PASSES - 1));

    // Clear on a new conversion, accumulate once per completed pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            pass_q <= '0;
        end else if (clr_i) begin
            sum_q  <= '0;
            pass_q <= '0;
        end else if (add_i) begin
            sum_q  <= sum_nxt;
            pass_q <= pass_q + SAR_PASS_W'(1);
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives the sample switch and DAC trial
// code, resolves one bit per cycle MSB first from the comparator, and hands the
// result out over valid/ready. All outputs are registered.
// Optional SAR_AVG4_EN: four SAMPLE/CONVERT passes per start, result = sum>>2.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS     = SAR_N_BITS,
    parameter int SAMPLE_CYC = SAR_SAMPLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_in,
    output logic              sample_en,
    output logic              cmp_en,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int BW  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SCW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    sar_state_e        state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [SCW-1:0]    scnt_q, scnt_d;
    logic [N_BITS-1:0] dac_q, dac_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              sample_en_q, sample_en_d;
    logic              cmp_en_q, cmp_en_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic [N_BITS-1:0] bit_mask;
    logic [N_BITS-1:0] kept;
    logic              pass_end;
    logic              sample_last;
    logic              last_pass;
    logic [N_BITS-1:0] final_code;

    // Trial bit under test; the comparator decides whether it survives.
    assign bit_mask    = N_BITS'(1) << bit_q;
    assign kept        = cmp_in ? dac_q : (dac_q & ~bit_mask);
    assign pass_end    = (state_q == CONVERT) && (bit_q == '0);
    assign sample_last = (scnt_q == SCW'(SAMPLE_CYC - 1));

`ifdef SAR_AVG4_EN
    sar_avg_accum #(
        .N_BITS (N_BITS)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  ((state_q == IDLE) && start),
        .add_i  (pass_end),
        .code_i (kept),
        .last_o (last_pass),
        .avg_o  (final_code)
    );
`else
    assign last_pass  = 1'b1;
    assign final_code = kept;
`endif

    // State register plus registered outputs and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_q       <= BW'(N_BITS - 1);
            scnt_q      <= '0;
            dac_q       <= '0;
            result_q    <= '0;
            sample_en_q <= 1'b0;
            cmp_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            scnt_q      <= scnt_d;
            dac_q       <= dac_d;
            result_q    <= result_d;
            sample_en_q <= sample_en_d;
            cmp_en_q    <= cmp_en_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state: start only in IDLE; start during DONE exit is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SAMPLE;
            SAMPLE:  if (sample_last) state_d = CONVERT;
            CONVERT: if (bit_q == '0) state_d = last_pass ? DONE : SAMPLE;
            DONE:    if (valid_q && result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values, derived from the upcoming state so that
    // every output is a flop.
    always_comb begin
        sample_en_d = (state_d == SAMPLE);
        cmp_en_d    = (state_d == CONVERT);
        busy_d      = (state_d != IDLE);
        valid_d     = (state_d == DONE);
        scnt_d      = ((state_q == SAMPLE) && (state_d == SAMPLE)) ? scnt_q + SCW'(1) : '0;
        // Counter only moves while staying in CONVERT, so it stops at 0.
        bit_d       = ((state_q == CONVERT) && (state_d == CONVERT)) ? bit_q - BW'(1)
                                                                     : BW'(N_BITS - 1);
        dac_d       = '0;
        if (state_d == CONVERT) begin
            if (state_q == CONVERT) dac_d = kept | (bit_mask >> 1);
            else                    dac_d = N_BITS'(1) << (N_BITS - 1);
        end
        result_d    = result_q;
        if (pass_end && last_pass) result_d = final_code;
    end

    assign sample_en    = sample_en_q;
    assign cmp_en       = cmp_en_q;
    assign dac_code     = dac_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: comparator modelled as vin >= dac_code.
module tb_sar_adc_ctrl;

`ifdef SAR_AVG4_EN
    localparam int PASSES = 4;
`else
    localparam int PASSES = 1;
`endif
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst, start, cmp_in, result_ready;
    logic       sample_en, cmp_en, busy, result_valid;
    logic [7:0] dac_code, result, vin;
    logic [7:0] dac_log [8];
    logic [7:0] a5_tbl  [8];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    assign cmp_in = (vin >= dac_code);

    sar_adc_ctrl #(.N_BITS(8), .SAMPLE_CYC(SC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cmp_in       (cmp_in),
        .sample_en    (sample_en),
        .cmp_en       (cmp_en),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {12'd0, sample_en, cmp_en, busy, result_valid, dac_code, result};
    endfunction

    // Pulse start from IDLE and walk every cycle up to the first valid cycle.
    task automatic run_conv(input logic [7:0] va, input logic [7:0] vb,
                            input logic [7:0] exp_res, input string tag);
        logic [7:0] code, trial;
        int spur, bad_se, bad_dac;
        vin = va; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        spur = 0; bad_se = 0; bad_dac = 0;
        for (int p = 0; p < PASSES; p++) begin
            vin = (p % 2) ? vb : va;
            for (int k = 0; k < SC; k++) begin
                if (!(sample_en && !cmp_en && dac_code == 8'h00 && busy)) bad_se++;
                if (result_valid) spur++;
                @(negedge clk);
            end
            code = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                trial = code | (8'd1 << i);
                if (dac_code !== trial || !cmp_en || sample_en || !busy) bad_dac++;
                if (p == 0) dac_log[7-i] = dac_code;
                if (result_valid) spur++;
                if (vin >= trial) code = trial;
                @(negedge clk);
            end
        end
        chk({tag, ".sample"}, bad_se, 0);
        chk({tag, ".trials"}, bad_dac, 0);
        chk({tag, ".early_valid"}, spur, 0);
        chk({tag, ".valid"}, {31'd0, result_valid}, 1);
        chk({tag, ".result"}, {24'd0, result}, {24'd0, exp_res});
        chk({tag, ".busy"}, {31'd0, busy}, 1);
    endtask

    task automatic chk_drop(input string tag);
        @(negedge clk);
        chk({tag, ".drop"}, {30'd0, result_valid, busy}, 0);
    endtask

    initial begin
        int hold_bad;
        a5_tbl = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        rst = 1'b1; start = 1'b0; result_ready = 1'b1; vin = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset.outs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.outs", outs(), 0);

        // Reference conversion and hand-derived trial sequence.
        run_conv(8'hA5, 8'hA5, 8'hA5, "a5");
        for (int i = 0; i < 8; i++) chk("a5.dac_tbl", {24'd0, dac_log[i]}, {24'd0, a5_tbl[i]});
        chk_drop("a5");

        // Back-to-back at the minimum start-to-start spacing; code extremes.
        run_conv(8'h00, 8'h00, 8'h00, "zero");
        chk_drop("zero");
        run_conv(8'hFF, 8'hFF, 8'hFF, "ones");
        chk_drop("ones");

        // Consumer stalls in DONE; a start pulse there must be ignored.
        result_ready = 1'b0;
        run_conv(8'h3C, 8'h3C, 8'h3C, "hold");
        hold_bad = 0;
        for (int j = 0; j < 10; j++) begin
            start = (j == 4);
            @(negedge clk);
            if (!(result_valid && result == 8'h3C && busy && !sample_en && !cmp_en)) hold_bad++;
        end
        chk("hold.stable", hold_bad, 0);
        result_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold.exit", {29'd0, result_valid, busy, sample_en}, 0);
        @(negedge clk);
        chk("hold.noqueue", {29'd0, result_valid, busy, sample_en}, 0);

        // Abort mid-conversion.
        vin = 8'h77; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort.in_convert", {31'd0, cmp_en}, 1);
        rst = 1'b1;
        #1;
        chk("abort.outs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.idle", outs(), 0);
        run_conv(8'h5A, 8'h5A, 8'h5A, "post_rst");
        chk_drop("post_rst");

`ifdef SAR_AVG4_EN
        run_conv(8'hA4, 8'hA6, 8'hA5, "avg");
        chk_drop("avg");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
